// File: rtl/logc_pkg.sv
// logc_pkg: constants and types shared by the log-compressor files.
//   GAIN_FRAC_DEFAULT : default fractional bits of cfg_gain (64 = 1.0)
//   SAT_WIDTH         : width of the saturation counter
//   logc_mode_e       : per-sample processing mode (log or linear bypass)
package logc_pkg;

  localparam int GAIN_FRAC_DEFAULT = 6;
  localparam int SAT_WIDTH = 16;

  typedef enum logic {
    LOGC_MODE_LOG    = 1'b0,
    LOGC_MODE_BYPASS = 1'b1
  } logc_mode_e;

endpackage

// File: rtl/logc_lod.sv
// logc_lod: combinational leading-one detect and normalise.
// Returns the Mitchell log2 approximation {e, frac} of x, where e is the
// index of the leading one and frac holds the FRAC_WIDTH bits directly
// below it, MSB-aligned and zero-padded.
// Ports:
//   x       in  DATA_WIDTH  unsigned sample
//   log_val out LOG_WIDTH   {e, frac}; 0 for x = 0
module logc_lod
  import logc_pkg::*;
#(
  parameter int DATA_WIDTH  = 48,
  parameter int FRAC_WIDTH  = 8,
  parameter int SHIFT_WIDTH = $clog2(DATA_WIDTH),
  parameter int LOG_WIDTH   = SHIFT_WIDTH + FRAC_WIDTH
) (
  input  logic [DATA_WIDTH-1:0] x,
  output logic [LOG_WIDTH-1:0]  log_val
);

  logic [SHIFT_WIDTH-1:0]           e;
  logic [DATA_WIDTH+FRAC_WIDTH-1:0] padded;
  logic [FRAC_WIDTH-1:0]            frac;

  // Priority encoder: the highest set bit wins because it is visited last.
  always_comb begin
    e = '0;
    for (int i = 0; i < DATA_WIDTH; i++) begin
      if (x[i]) e = SHIFT_WIDTH'(i);
    end
  end

  // Appending FRAC_WIDTH zeros below x means bits e-1 .. e-FRAC_WIDTH of x
  // sit at padded[e +: FRAC_WIDTH]; short tails are zero-filled for free.
  assign padded  = {x, {FRAC_WIDTH{1'b0}}};
  assign frac    = padded[e +: FRAC_WIDTH];
  assign log_val = {e, frac};

endmodule

// File: rtl/logc_stream.sv
// logc_stream: three-stage valid/ready log compressor for envelope samples.
//   stage 1: register sample, tag, last flag and the configuration
//   stage 2: Mitchell log2 (or linear clamp for bypass)
//   stage 3: offset, gain, shift and clamp to OUT_WIDTH
// Ports:
//   clk, reset                       clock, synchronous active-high reset
//   in_valid/in_ready/in_data/in_ch/in_last    input stream
//   cfg_mode/cfg_offset/cfg_gain     configuration, captured per sample
//   sat_clr                          clears sat_count
//   out_valid/out_ready/out_data/out_ch/out_last output stream
//   sat_count                        saturating count of clamped outputs
module logc_stream
  import logc_pkg::*;
#(
  parameter int DATA_WIDTH  = 48,
  parameter int FRAC_WIDTH  = 8,
  parameter int SHIFT_WIDTH = $clog2(DATA_WIDTH),
  parameter int LOG_WIDTH   = SHIFT_WIDTH + FRAC_WIDTH,
  parameter int OUT_WIDTH   = 8,
  parameter int GAIN_WIDTH  = 8,
  parameter int GAIN_FRAC   = GAIN_FRAC_DEFAULT,
  parameter int OUT_SHIFT   = 5,
  parameter int CH_WIDTH    = 4,
  parameter logic [DATA_WIDTH-1:0] MIN_THRESHOLD = '0
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] in_data,
  input  logic [CH_WIDTH-1:0]   in_ch,
  input  logic                  in_last,
  input  logic                  cfg_mode,
  input  logic [LOG_WIDTH-1:0]  cfg_offset,
  input  logic [GAIN_WIDTH-1:0] cfg_gain,
  input  logic                  sat_clr,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [OUT_WIDTH-1:0]  out_data,
  output logic [CH_WIDTH-1:0]   out_ch,
  output logic                  out_last,
  output logic [SAT_WIDTH-1:0]  sat_count
);

  localparam int PROD_WIDTH = LOG_WIDTH + GAIN_WIDTH;
  localparam logic [OUT_WIDTH-1:0] OUT_MAX = '1;

  // Stage 1
  logic                  s1_valid;
  logic [DATA_WIDTH-1:0] s1_data;
  logic [CH_WIDTH-1:0]   s1_ch;
  logic                  s1_last;
  logc_mode_e            s1_mode;
  logic [LOG_WIDTH-1:0]  s1_offset;
  logic [GAIN_WIDTH-1:0] s1_gain;
  // Stage 2
  logic                  s2_valid;
  logic [LOG_WIDTH-1:0]  s2_log;
  logic [OUT_WIDTH-1:0]  s2_byp;
  logic                  s2_byp_sat;
  logic [CH_WIDTH-1:0]   s2_ch;
  logic                  s2_last;
  logc_mode_e            s2_mode;
  logic [LOG_WIDTH-1:0]  s2_offset;
  logic [GAIN_WIDTH-1:0] s2_gain;
  // Stage 3
  logic                  s3_valid;
  logic [OUT_WIDTH-1:0]  s3_data;
  logic                  s3_sat;
  logic [CH_WIDTH-1:0]   s3_ch;
  logic                  s3_last;

  logic s1_load, s2_load, s3_load;

  // Ready chain: a stage may load when empty or when its content leaves.
  assign s3_load  = !s3_valid || out_ready;
  assign s2_load  = !s2_valid || s3_load;
  assign s1_load  = !s1_valid || s2_load;
  assign in_ready = s1_load;

  // Stage 2 combinational: log2 with threshold, bypass clamp.
  logic [LOG_WIDTH-1:0] lod_val, log_next;
  logic                 byp_sat_next;
  logic [OUT_WIDTH-1:0] byp_next;

  logc_lod #(
    .DATA_WIDTH (DATA_WIDTH),
    .FRAC_WIDTH (FRAC_WIDTH),
    .SHIFT_WIDTH(SHIFT_WIDTH),
    .LOG_WIDTH  (LOG_WIDTH)
  ) u_lod (
    .x      (s1_data),
    .log_val(lod_val)
  );

  assign log_next     = (s1_data <= MIN_THRESHOLD) ? '0 : lod_val;
  assign byp_sat_next = |s1_data[DATA_WIDTH-1:OUT_WIDTH];
  assign byp_next     = byp_sat_next ? OUT_MAX : s1_data[OUT_WIDTH-1:0];

  // Stage 3 combinational: floor at zero, full-width product, clamp.
  logic [LOG_WIDTH-1:0]  diff;
  logic [PROD_WIDTH-1:0] prod, scaled;
  logic                  log_sat;
  logic [OUT_WIDTH-1:0]  log_code;

  assign diff     = (s2_log > s2_offset) ? (s2_log - s2_offset) : '0;
  assign prod     = PROD_WIDTH'(diff) * PROD_WIDTH'(s2_gain);
  assign scaled   = prod >> (GAIN_FRAC + OUT_SHIFT);
  assign log_sat  = |scaled[PROD_WIDTH-1:OUT_WIDTH];
  assign log_code = log_sat ? OUT_MAX : scaled[OUT_WIDTH-1:0];

  // Valid bits are the only pipeline state that needs a reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      s1_valid <= 1'b0;
      s2_valid <= 1'b0;
      s3_valid <= 1'b0;
    end else begin
      if (s1_load) s1_valid <= in_valid;
      if (s2_load) s2_valid <= s1_valid;
      if (s3_load) s3_valid <= s2_valid;
    end
  end

  always_ff @(posedge clk) begin
    if (s1_load) begin
      s1_data   <= in_data;
      s1_ch     <= in_ch;
      s1_last   <= in_last;
      s1_mode   <= logc_mode_e'(cfg_mode);
      s1_offset <= cfg_offset;
      s1_gain   <= cfg_gain;
    end
    if (s2_load) begin
      s2_log     <= log_next;
      s2_byp     <= byp_next;
      s2_byp_sat <= byp_sat_next;
      s2_ch      <= s1_ch;
      s2_last    <= s1_last;
      s2_mode    <= s1_mode;
      s2_offset  <= s1_offset;
      s2_gain    <= s1_gain;
    end
    if (s3_load) begin
      s3_data <= (s2_mode == LOGC_MODE_BYPASS) ? s2_byp : log_code;
      s3_sat  <= (s2_mode == LOGC_MODE_BYPASS) ? s2_byp_sat : log_sat;
      s3_ch   <= s2_ch;
      s3_last <= s2_last;
    end
  end

  // Clear takes priority over a same-cycle increment; count sticks at max.
  always_ff @(posedge clk) begin
    if (reset || sat_clr) begin
      sat_count <= '0;
    end else if (s3_valid && out_ready && s3_sat && (sat_count != '1)) begin
      sat_count <= sat_count + 1'b1;
    end
  end

  assign out_valid = s3_valid;
  assign out_data  = s3_data;
  assign out_ch    = s3_ch;
  assign out_last  = s3_last;

endmodule

// File: tb/tb_logc_stream.sv
// tb_logc_stream: directed bench for logc_stream with a scoreboard model
// computing expected codes from floor(log2) arithmetic.
module tb_logc_stream;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [47:0] in_data = '0;
  logic [3:0]  in_ch = '0;
  logic        in_last = 1'b0;
  logic        cfg_mode = 1'b0;
  logic [13:0] cfg_offset = '0;
  logic [7:0]  cfg_gain = 8'd64;
  logic        sat_clr = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [7:0]  out_data;
  logic [3:0]  out_ch;
  logic        out_last;
  logic [15:0] sat_count;

  logc_stream dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .in_ch(in_ch), .in_last(in_last),
    .cfg_mode(cfg_mode), .cfg_offset(cfg_offset), .cfg_gain(cfg_gain),
    .sat_clr(sat_clr),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_ch(out_ch), .out_last(out_last), .sat_count(sat_count)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [7:0] data;
    logic [3:0] ch;
    logic       last;
    bit         sat;
    int         acc;
  } exp_t;

  typedef struct {
    logic [7:0] data;
    logic [3:0] ch;
    logic       last;
  } obs_t;

  exp_t exp_q[$];
  obs_t obs_q[$];
  int   n_checks = 0;
  int   n_fail = 0;
  bit   chk_en = 1'b0;

  task automatic check(input bit ok, input string name,
                       input longint unsigned act, input longint unsigned expv);
    n_checks++;
    if (!ok) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, expv);
    end
  endtask

  // Unclamped result: floor(log2 x) plus the fraction (x - 2^e) / 2^e
  // scaled to 256ths, then offset, gain and divide by 2^(6+5).
  function automatic longint unsigned model_raw(input longint unsigned x,
      input bit mode, input longint unsigned off, input longint unsigned gain);
    longint unsigned l, d, pow;
    int e;
    if (mode) return x;
    l = 0;
    if (x > 0) begin
      e = 0;
      for (int b = 0; b < 63; b++) if (x >= (64'd1 << b)) e = b;
      pow = 64'd1 << e;
      l = longint'(e) * 256 + (((x - pow) * 256) >> e);
    end
    d = (l > off) ? l - off : 0;
    return (d * gain) / 2048;
  endfunction

  task automatic monitor();
    logic [15:0] m_sat;
    bit          hold;
    logic [7:0]  h_data;
    logic [3:0]  h_ch;
    logic        h_last;
    int          last_stall;
    exp_t        e;
    longint unsigned raw;
    m_sat = '0; hold = 0; last_stall = 0;
    h_data = '0; h_ch = '0; h_last = 1'b0;
    forever begin
      @(negedge clk);
      if (chk_en) begin
        check(sat_count == m_sat, "sat_count", sat_count, m_sat);
        if (reset) begin
          exp_q.delete();
          m_sat = '0;
          hold = 0;
          last_stall = cyc;
        end else begin
          if (hold)
            check(out_valid && out_data == h_data && out_ch == h_ch && out_last == h_last,
                  "stall_stable", {out_valid, out_data, out_ch, out_last},
                  {1'b1, h_data, h_ch, h_last});
          if (out_valid && exp_q.size() == 0) begin
            check(1'b0, "unexpected_out", out_data, 0);
          end else if (out_valid && out_ready) begin
            e = exp_q.pop_front();
            check(out_data == e.data, "out_data", out_data, e.data);
            check(out_ch == e.ch, "out_ch", out_ch, e.ch);
            check(out_last == e.last, "out_last", out_last, e.last);
            if (e.acc > last_stall)
              check(cyc - e.acc == 3, "latency", cyc - e.acc, 3);
            obs_q.push_back('{out_data, out_ch, out_last});
            if (e.sat && m_sat != 16'hFFFF) m_sat = m_sat + 1'b1;
          end
          if (sat_clr) m_sat = '0;
          hold = out_valid && !out_ready;
          h_data = out_data; h_ch = out_ch; h_last = out_last;
          if (!out_ready) last_stall = cyc;
          if (in_valid && in_ready) begin
            raw = model_raw(in_data, cfg_mode, cfg_offset, cfg_gain);
            e.data = (raw > 255) ? 8'd255 : raw[7:0];
            e.sat  = raw > 255;
            e.ch   = in_ch;
            e.last = in_last;
            e.acc  = cyc;
            exp_q.push_back(e);
          end
        end
      end
    end
  endtask

  // Called at posedge+1; returns at posedge+1 after the sample is taken.
  task automatic send(input longint unsigned x, input int ch, input bit last);
    bit done;
    done = 0;
    in_data = x[47:0]; in_ch = ch[3:0]; in_last = last; in_valid = 1'b1;
    for (int k = 0; k < 200 && !done; k++) begin
      @(negedge clk);
      if (in_ready) done = 1;
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    check(done, "accept_timeout", done, 1);
  endtask

  task automatic run_single(input longint unsigned x, input int expv, input string name);
    int lat;
    bit seen;
    lat = 0; seen = 0;
    send(x, 0, 1'b0);
    while (!seen && lat < 20) begin
      @(negedge clk);
      lat++;
      if (out_valid) seen = 1;
    end
    check(seen && lat == 3, {name, "_latency"}, lat, 3);
    check(out_data == expv[7:0], name, out_data, expv);
    @(posedge clk); #1;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    longint unsigned p20, p21, p47;
    p20 = 64'd1 << 20; p21 = 64'd1 << 21; p47 = 64'd1 << 47;
    fork monitor(); join_none

    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    chk_en = 1'b1;
    @(negedge clk);
    check(out_valid == 1'b0, "rst_out_valid", out_valid, 0);
    check(in_ready == 1'b1, "rst_in_ready", in_ready, 1);
    check(sat_count == 16'd0, "rst_sat_count", sat_count, 0);
    @(posedge clk); #1;

    // Pin the model to hand-computed values.
    check(model_raw(p20, 0, 0, 64) == 160, "model_p20", model_raw(p20, 0, 0, 64), 160);
    check(model_raw(64'h300000, 0, 0, 64) == 172, "model_300000",
          model_raw(64'h300000, 0, 0, 64), 172);
    check(model_raw(p47, 0, 0, 64) == 376, "model_p47", model_raw(p47, 0, 0, 64), 376);
    check(model_raw(256, 0, 2560, 64) == 0, "model_floor", model_raw(256, 0, 2560, 64), 0);

    run_single(p20, 160, "x_2p20");
    run_single(64'h300000, 172, "x_300000");
    run_single(0, 0, "x_zero");
    run_single(1, 0, "x_one");
    cfg_gain = 8'd32;
    run_single(p20, 80, "gain32");
    cfg_gain = 8'd64; cfg_offset = 14'd2560;
    run_single(p20, 80, "offset_2p20");
    run_single(256, 0, "offset_2p8");
    cfg_offset = '0;
    run_single(p47, 255, "x_2p47");
    check(sat_count == 16'd1, "sat_after_2p47", sat_count, 1);

    cfg_mode = 1'b1;
    run_single(200, 200, "byp_200");
    run_single(300, 255, "byp_300");
    check(sat_count == 16'd2, "sat_after_byp", sat_count, 2);
    sat_clr = 1'b1;
    run_single(300, 255, "byp_300_clr");
    sat_clr = 1'b0;
    check(sat_count == 16'd0, "sat_clr_wins", sat_count, 0);
    cfg_mode = 1'b0;

    // Gain change between two back-to-back samples.
    obs_q.delete();
    send(p20, 1, 1'b0);
    cfg_gain = 8'd32;
    send(p20, 2, 1'b1);
    cfg_gain = 8'd64;
    repeat (6) @(posedge clk);
    #1;
    if (obs_q.size() == 2) begin
      check(obs_q[0].data == 8'd160, "cfg_mid_first", obs_q[0].data, 160);
      check(obs_q[1].data == 8'd80, "cfg_mid_second", obs_q[1].data, 80);
    end else begin
      check(1'b0, "cfg_mid_count", obs_q.size(), 2);
    end

    // Backpressure: 8 samples, out_ready low for 10 cycles mid-stream.
    obs_q.delete();
    fork
      begin
        for (int i = 0; i < 8; i++) send(64'd1000 * (i + 1), i, i == 7);
      end
      begin
        repeat (3) @(posedge clk);
        #1 out_ready = 1'b0;
        repeat (7) @(posedge clk);
        @(negedge clk);
        check(in_ready == 1'b0, "bp_in_ready", in_ready, 0);
        check(out_valid == 1'b1, "bp_out_valid", out_valid, 1);
        check(exp_q.size() == 3, "bp_held", exp_q.size(), 3);
        repeat (3) @(posedge clk);
        #1 out_ready = 1'b1;
      end
    join
    repeat (8) @(posedge clk);
    #1;
    check(obs_q.size() == 8, "bp_count", obs_q.size(), 8);
    foreach (obs_q[i]) begin
      check(obs_q[i].ch == i[3:0], "bp_ch_order", obs_q[i].ch, i);
      check(obs_q[i].last == (i == 7), "bp_last", obs_q[i].last, (i == 7));
    end

    // Mid-stream reset with two samples in flight.
    run_single(p47, 255, "presat");
    send(p20, 3, 1'b0);
    send(p21, 4, 1'b0);
    reset = 1'b1;
    @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    check(out_valid == 1'b0, "midrst_out_valid", out_valid, 0);
    check(in_ready == 1'b1, "midrst_in_ready", in_ready, 1);
    check(sat_count == 16'd0, "midrst_sat", sat_count, 0);
    repeat (5) @(posedge clk);
    #1;
    run_single(p20, 160, "post_reset");

    repeat (4) @(posedge clk);
    #1;
    check(exp_q.size() == 0, "drain", exp_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
